i2s_transmitter: RTL and testbench

- Final output stage of the synth audio path. Consumes stereo 24-bit samples from the sample-rate/mixing stage through a valid/ready handshake.
- Serializes them onto an I2S bus at 44.1 kHz from the 16.9344 MHz audio clock: 384 clocks/frame, 64 BCLK/frame.
- Holds one frame in a single-entry buffer. Repeats the last frame on underrun so the DAC never sees a glitch.

---
 rtl/i2s_transmitter.sv | 118 +++++++++++
 tb/tb_i2s_transmitter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// I2S output stage: single-entry stereo hold buffer feeding a 64-BCLK frame serializer.
// The last frame is replayed whenever upstream misses a frame boundary.
module i2s_transmitter #(
  parameter int AUDIO_CLOCK       = 16934400,
  parameter int AUDIO_SAMPLE_RATE = 44100,
  parameter int AUDIO_BIT_WIDTH   = 24,
  parameter int SLOT_WIDTH        = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_left,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] sample_right,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  output logic                              i2s_bclk,
  output logic                              i2s_lrck,
  output logic                              i2s_sdata,
  output logic                              frame_start,
  output logic                              underrun
);

  localparam int CLKS_PER_FRAME = AUDIO_CLOCK / AUDIO_SAMPLE_RATE;
  localparam int BITS_PER_FRAME = 2 * SLOT_WIDTH;
  localparam int BCLK_DIV       = CLKS_PER_FRAME / BITS_PER_FRAME;
  localparam int DIV_W          = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W          = $clog2(BITS_PER_FRAME);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_FRAME - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_WIDTH);

  if ((AUDIO_CLOCK % AUDIO_SAMPLE_RATE != 0) || (CLKS_PER_FRAME % BITS_PER_FRAME != 0) ||
      (BCLK_DIV < 2) || (BCLK_DIV % 2 != 0) || (AUDIO_BIT_WIDTH > SLOT_WIDTH - 1)) begin : g_param_check
    $error("i2s_transmitter: clock/rate/slot/width parameters are inconsistent");
  end

  // Slot position 1..AUDIO_BIT_WIDTH carries the sample MSB first; everything else is zero.
  function automatic logic pick_bit(input logic [AUDIO_BIT_WIDTH-1:0] s,
                                    input logic [BIT_W-1:0] pos);
    logic b;
    b = 1'b0;
    for (int i = 0; i < AUDIO_BIT_WIDTH; i++) begin
      if (pos == BIT_W'(AUDIO_BIT_WIDTH - i)) b = s[i];
    end
    return b;
  endfunction

  logic [DIV_W-1:0]                 div_cnt;
  logic [BIT_W-1:0]                 bit_cnt;
  logic                             wrap_pending;
  logic                             hold_full;
  logic signed [AUDIO_BIT_WIDTH-1:0] hold_left, hold_right;
  logic signed [AUDIO_BIT_WIDTH-1:0] tx_left, tx_right;

  logic                             bit_edge, wrap_edge, load_hold, accept, in_right, next_sdata;
  logic [DIV_W-1:0]                 div_next;
  logic [BIT_W-1:0]                 bit_next, slot_pos;
  logic signed [AUDIO_BIT_WIDTH-1:0] tx_left_next, tx_right_next;

  assign sample_ready = !hold_full && !reset;
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    bit_edge      = (div_cnt == DIV_LAST);
    // The first bit edge after reset starts a frame at bit 0 rather than advancing.
    wrap_edge     = bit_edge && (wrap_pending || (bit_cnt == BIT_LAST));
    load_hold     = wrap_edge && hold_full;
    div_next      = bit_edge ? '0 : div_cnt + 1'b1;
    bit_next      = wrap_edge ? '0 : bit_cnt + 1'b1;
    in_right      = (bit_next >= SLOT);
    slot_pos      = in_right ? bit_next - SLOT : bit_next;
    tx_left_next  = load_hold ? hold_left  : tx_left;
    tx_right_next = load_hold ? hold_right : tx_right;
    next_sdata    = in_right ? pick_bit(tx_right_next, slot_pos)
                             : pick_bit(tx_left_next, slot_pos);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      wrap_pending <= 1'b1;
      hold_full    <= 1'b0;
      tx_left      <= '0;
      tx_right     <= '0;
      i2s_bclk     <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      div_cnt     <= div_next;
      i2s_bclk    <= (div_next >= DIV_HALF);
      frame_start <= wrap_edge;
      underrun    <= wrap_edge && !hold_full;
      if (bit_edge) begin
        bit_cnt      <= bit_next;
        wrap_pending <= 1'b0;
        i2s_lrck     <= in_right;
        i2s_sdata    <= next_sdata;
      end
      // On underrun the transmit registers simply keep the previous frame.
      tx_left  <= tx_left_next;
      tx_right <= tx_right_next;
      if (load_hold) hold_full <= 1'b0;
      else if (accept) hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      hold_left  <= sample_left;
      hold_right <= sample_right;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: startup vector table, then frame scoreboard scenarios
// (bit accuracy, backpressure, underrun repeat, wrap-edge race, mid-frame reset).
module tb_i2s_transmitter;

  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         ur;
  } frame_t;

  typedef struct {
    logic       rst;
    logic [5:0] exp;  // {ready, bclk, lrck, sdata, frame_start, underrun}
  } vec_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sample_left = '0;
  logic [W-1:0] sample_right = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun;

  i2s_transmitter dut (
    .clock        (clock),
    .reset        (reset),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  int     total = 0;
  int     bad = 0;
  int     done = 0;
  int     cyc = 0;
  frame_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame monitor: pops the expected frame on frame_start and captures 64 bits on BCLK rises.
  logic        cap_active = 1'b0;
  logic        prev_bclk = 1'b0;
  logic        prev_fs = 1'b0;
  logic        lrck_bad = 1'b0;
  int          nbit = 0;
  logic [63:0] cap = '0;
  frame_t      cur;

  always @(negedge clock) begin
    if (reset) begin
      cap_active = 1'b0;
      prev_bclk  = 1'b0;
      prev_fs    = 1'b0;
    end else begin
      if (underrun) chk("underrun_with_frame_start", frame_start, 1);
      if (frame_start) begin
        chk("frame_start_width", prev_fs, 0);
        chk("sb_frame_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          chk("underrun_flag", underrun, cur.ur);
          cap_active = 1'b1;
          nbit       = 0;
          cap        = '0;
          lrck_bad   = 1'b0;
        end else begin
          cap_active = 1'b0;
        end
      end
      if (cap_active && !prev_bclk && i2s_bclk) begin
        cap[63-nbit] = i2s_sdata;
        if (i2s_lrck !== (nbit >= 32)) lrck_bad = 1'b1;
        nbit++;
        if (nbit == 64) begin
          chk("frame_bits", cap, {1'b0, cur.l, 7'b0, 1'b0, cur.r, 7'b0});
          chk("lrck_slot", lrck_bad, 0);
          done++;
          cap_active = 1'b0;
        end
      end
      prev_bclk = i2s_bclk;
      prev_fs   = frame_start;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic tick_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r, input logic ur);
    frame_t f;
    f.l = l;
    f.r = r;
    f.ur = ur;
    sb.push_back(f);
  endtask

  task automatic wait_done(input int target);
    int guard = 0;
    while (done < target && guard < 2000) begin
      tick();
      guard++;
    end
    if (done < target) chk("timeout_frames_done", done, target);
  endtask

  task automatic wait_level(input int which, input logic lvl, output int at);
    int guard = 0;
    while (((which == 0) ? i2s_bclk : i2s_lrck) !== lvl && guard < 1000) begin
      tick();
      guard++;
    end
    if (guard >= 1000) chk("timeout_wait_level", 0, 1);
    at = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun}, 0);
    chk("sb_drained", sb.size(), 0);
    reset = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [W-1:0] bp_left(input int k);
    return W'(24'hC00000 + k);
  endfunction

  function automatic logic [W-1:0] bp_right(input int k);
    return W'(24'h3FFF00 - k);
  endfunction

  initial begin
    vec_t vecs[14];
    int   t1, t2, t3, base, k;
    logic acc, exp_acc;

    for (int i = 0; i < 5; i++) begin
      vecs[i].rst = 1'b1;
      vecs[i].exp = 6'b000000;
    end
    for (int i = 5; i < 14; i++) vecs[i].rst = 1'b0;
    vecs[5].exp  = 6'b100000;
    vecs[6].exp  = 6'b100000;
    vecs[7].exp  = 6'b110000;
    vecs[8].exp  = 6'b110000;
    vecs[9].exp  = 6'b110000;
    vecs[10].exp = 6'b100011;
    vecs[11].exp = 6'b100000;
    vecs[12].exp = 6'b100000;
    vecs[13].exp = 6'b110000;

    // Startup: reset held 5 cycles, then free-running with no samples offered.
    push('0, '0, 1'b1);
    push('0, '0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst;
      if (i == 5) cyc = 0;
      tick();
      chk($sformatf("startup_row%0d", i),
          {sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun}, vecs[i].exp);
    end
    wait_level(0, 1'b0, t1);
    wait_level(0, 1'b1, t1);
    wait_level(0, 1'b0, t2);
    wait_level(0, 1'b1, t2);
    chk("bclk_period", t2 - t1, 6);
    wait_level(1, 1'b1, t1);
    wait_level(1, 1'b0, t2);
    wait_level(1, 1'b1, t3);
    chk("lrck_high_time", t2 - t1, 192);
    chk("lrck_period", t3 - t1, 384);
    wait_done(2);
    do_reset();

    // Bit accuracy: one frame offered before the first wrap.
    base = done;
    push(24'hA5C3F1, 24'h5A3C0F, 1'b0);
    send(24'hA5C3F1, 24'h5A3C0F);
    tick();
    sample_valid = 1'b0;
    chk("ready_after_accept", sample_ready, 0);
    wait_done(base + 1);
    do_reset();

    // Backpressure: valid held high with a new frame after every handshake.
    base = done;
    for (int i = 0; i < 4; i++) push(bp_left(i), bp_right(i), 1'b0);
    k = 0;
    send(bp_left(0), bp_right(0));
    while (done < base + 4 && cyc < 2000) begin
      @(negedge clock);
      acc = sample_valid && sample_ready;
      tick();
      exp_acc = (cyc == 1) || (cyc >= 7 && (cyc - 7) % 384 == 0);
      if (acc || exp_acc) chk($sformatf("bp_accept_cycle%0d", cyc), acc, exp_acc);
      if (acc) begin
        chk("bp_ready_drop", sample_ready, 0);
        k++;
        send(bp_left(k), bp_right(k));
      end
      if (cyc >= 6 && (cyc - 6) % 384 == 0) chk("bp_ready_back", sample_ready, 1);
    end
    if (done < base + 4) chk("timeout_backpressure", done, base + 4);
    sample_valid = 1'b0;
    do_reset();

    // Underrun: one frame then silence; the frame repeats with an underrun pulse.
    base = done;
    push(24'h000001, 24'hFFFFFF, 1'b0);
    push(24'h000001, 24'hFFFFFF, 1'b1);
    send(24'h000001, 24'hFFFFFF);
    tick();
    sample_valid = 1'b0;
    tick_until(390);
    chk("underrun_pulse_on", {frame_start, underrun}, 2'b11);
    tick();
    chk("underrun_pulse_off", {frame_start, underrun}, 2'b00);
    wait_done(base + 2);
    do_reset();

    // Race: valid only on the second wrap-edge cycle with the buffer empty.
    base = done;
    push('0, '0, 1'b1);
    push('0, '0, 1'b1);
    push(24'h800000, 24'h7FFFFF, 1'b0);
    tick_until(389);
    send(24'h800000, 24'h7FFFFF);
    tick();
    sample_valid = 1'b0;
    chk("race_edge_flags", {frame_start, underrun, sample_ready}, 3'b110);
    wait_done(base + 3);
    do_reset();

    // Mid-frame reset with a frame waiting in the hold buffer.
    push(24'h123456, 24'h654321, 1'b0);
    send(24'h123456, 24'h654321);
    tick();
    sample_valid = 1'b0;
    tick_until(6);
    send(24'hABCDEF, 24'hFEDCBA);
    tick();
    sample_valid = 1'b0;
    chk("mid_hold_full", sample_ready, 0);
    tick_until(246);
    chk("mid_lrck_bit40", i2s_lrck, 1);
    do_reset();
    base = done;
    push('0, '0, 1'b1);
    wait_done(base + 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
